// File: rtl/rr_mux4_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
// Build option: define RR_MUX4_STATS_EN for per-channel grant counters.
package rr_mux4_pkg;
  localparam int DW   = 32;
  localparam int NCH  = 4;
  localparam int SELW = 2;
  localparam int CNTW = 16;

  typedef logic [SELW-1:0] sel_t;
  typedef logic [DW-1:0]   data_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Observable internals: output-slot state and round-robin pointer.
  typedef struct packed {
    slot_state_e state;
    sel_t        ptr;
  } dbg_t;
endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first set request at or after ptr, wrapping modulo 4.
module rr_pick4
  import rr_mux4_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  sel_t           ptr,
  output logic           gnt_valid,
  output sel_t           gnt_idx
);
  sel_t idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    idx       = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + k[SELW-1:0];
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter over four valid/ready channels feeding one registered output slot.
// Build option: RR_MUX4_STATS_EN adds the saturating grant_cnt port.
module rr_mux4_arbiter
  import rr_mux4_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in_valid,
  input  logic [DW-1:0]  in_data0,
  input  logic [DW-1:0]  in_data1,
  input  logic [DW-1:0]  in_data2,
  input  logic [DW-1:0]  in_data3,
  output logic [NCH-1:0] in_ready,
  output logic           out_valid,
  output logic [DW-1:0]  out_data,
  output logic [SELW-1:0] out_sel,
  input  logic           out_ready,
  output dbg_t           dbg_o
`ifdef RR_MUX4_STATS_EN
  ,
  output logic [NCH*CNTW-1:0] grant_cnt
`endif
);
  // Handshake: a word moves on any edge where valid and ready are both high;
  // in_ready never depends on in_data, and a channel may drop valid freely.
  slot_state_e    state_q, state_d;
  sel_t           ptr_q, ptr_d;
  data_t          data_q, data_d;
  sel_t           sel_q, sel_d;
  logic           gnt_valid;
  sel_t           gnt_idx;
  logic           load;
  logic           accept;
  data_t          mux_data;
  logic [NCH-1:0] one_hot;

  rr_pick4 u_pick (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    mux_data = in_data0;
    case (gnt_idx)
      2'd0: mux_data = in_data0;
      2'd1: mux_data = in_data1;
      2'd2: mux_data = in_data2;
      2'd3: mux_data = in_data3;
      default: mux_data = in_data0;
    endcase
  end

  assign load   = (state_q == SLOT_EMPTY) || out_ready;
  assign accept = !rst && gnt_valid && load;

  always_ff @(posedge clk) begin
    if (rst) state_q <= SLOT_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !accept) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    one_hot          = '0;
    one_hot[gnt_idx] = 1'b1;
    out_valid        = (state_q == SLOT_FULL);
    in_ready         = accept ? one_hot : '0;
  end

  // Pointer and slot contents only change on an accepted transfer.
  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (accept) begin
      ptr_d  = gnt_idx + 2'd1;
      data_d = mux_data;
      sel_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign out_data    = data_q;
  assign out_sel     = sel_q;
  assign dbg_o.state = state_q;
  assign dbg_o.ptr   = ptr_q;

`ifdef RR_MUX4_STATS_EN
  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    logic [CNTW-1:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (accept && (gnt_idx == sel_t'(i)) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign grant_cnt[i*CNTW +: CNTW] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: directed literal checks plus randomized traffic
// against a per-cycle behavioural model; RR_MUX4_STATS_EN also covers grant_cnt.
module tb_rr_mux4_arbiter;
  import rr_mux4_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data [4];
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
  dbg_t        dbg;
`ifdef RR_MUX4_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model of the observable state.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [1:0]  m_sel   = '0;
  int          m_ptr   = 0;
  int          m_cnt [4] = '{0, 0, 0, 0};
  logic [33:0] exp_q [$];

  rr_mux4_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data[0]),
    .in_data1  (in_data[1]),
    .in_data2  (in_data[2]),
    .in_data3  (in_data[3]),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .dbg_o     (dbg)
`ifdef RR_MUX4_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: inputs change 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / model compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    int          w;
    logic        found;
    logic [3:0]  er;
    logic [33:0] front;
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && in_valid[(m_ptr + k) % 4]) begin
        found = 1'b1;
        w     = (m_ptr + k) % 4;
      end
    end
    er = (!rst && found && (!m_valid || out_ready)) ? (4'b0001 << w) : 4'b0000;
    chk("m_in_ready", 64'(in_ready), 64'(er));
    chk("m_out_valid", 64'(out_valid), 64'(m_valid));
    chk("m_state", 64'(dbg.state == SLOT_FULL), 64'(m_valid));
    chk("m_out_data", 64'(out_data), 64'(m_data));
    chk("m_out_sel", 64'(out_sel), 64'(m_sel));
    chk("m_ptr", 64'(dbg.ptr), 64'(m_ptr));
`ifdef RR_MUX4_STATS_EN
    for (int i = 0; i < 4; i++) chk("m_grant_cnt", 64'(grant_cnt[16*i +: 16]), 64'(m_cnt[i]));
`endif
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = '0;
      m_ptr   = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      exp_q.delete();
    end else begin
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("drain_queue_empty", 64'(exp_q.size()), 64'd1);
        end else begin
          front = exp_q.pop_front();
          chk("drain_word", 64'({out_sel, out_data}), 64'(front));
        end
      end
      if (er != 4'b0000) begin
        m_valid = 1'b1;
        m_data  = in_data[w];
        m_sel   = 2'(w);
        m_ptr   = (w + 1) % 4;
        exp_q.push_back({2'(w), in_data[w]});
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) in_data[i] = 32'hA0 + 32'(i);

    // Reset state; in_ready held low while rst is high.
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_sel", 64'(out_sel), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);

    // All four valid, streaming: selects 0,1,2,3,0.
    cyc();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rr_first_ready", 64'(in_ready), 64'h1);
    chk("rr_first_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_valid", 64'(out_valid), 64'h1);
      chk("rr_sel", 64'(out_sel), 64'(i % 4));
      chk("rr_data", 64'(out_data), 64'(32'hA0 + 32'(i % 4)));
    end

    // Wrap: grant 1 so ptr=2, then 0011 grants 0 then 1.
    cyc();
    rst      = 1'b1;
    in_valid = 4'b0000;
    cyc();
    rst      = 1'b0;
    in_valid = 4'b0010;
    @(negedge clk);
    chk("wrap_first", 64'(in_ready), 64'h2);
    cyc();
    in_valid = 4'b0011;
    @(negedge clk);
    chk("wrap_rdy0", 64'(in_ready), 64'h1);
    chk("wrap_ptr2", 64'(dbg.ptr), 64'h2);
    @(negedge clk);
    chk("wrap_rdy1", 64'(in_ready), 64'h2);
    chk("wrap_ptr1", 64'(dbg.ptr), 64'h1);
    @(negedge clk);
    chk("wrap_ptr2b", 64'(dbg.ptr), 64'h2);
    chk("wrap_sel1", 64'(out_sel), 64'h1);

    // Stall for 3 cycles with everything valid, then release.
    cyc();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 64'(in_ready), 64'h0);
      chk("stall_valid", 64'(out_valid), 64'h1);
      chk("stall_sel", 64'(out_sel), 64'h0);
      chk("stall_data", 64'(out_data), 64'hA0);
      chk("stall_ptr", 64'(dbg.ptr), 64'h1);
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", 64'(in_ready), 64'h2);
    chk("release_valid", 64'(out_valid), 64'h1);
    @(negedge clk);
    chk("release_sel", 64'(out_sel), 64'h1);
    chk("release_data", 64'(out_data), 64'hA1);
    chk("release_valid2", 64'(out_valid), 64'h1);

    // Lone requester on channel 3.
    cyc();
    in_valid   = 4'b1000;
    in_data[3] = 32'hDEADBEEF;
    @(negedge clk);
    chk("solo_ready0", 64'(in_ready), 64'h8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("solo_ready", 64'(in_ready), 64'h8);
      chk("solo_sel", 64'(out_sel), 64'h3);
      chk("solo_data", 64'(out_data), 64'hDEADBEEF);
      chk("solo_ptr", 64'(dbg.ptr), 64'h0);
    end

    // Reset while a word is pending.
    cyc();
    in_data[3] = 32'hA3;
    in_valid   = 4'b1111;
    out_ready  = 1'b0;
    @(negedge clk);
    chk("midrst_pending", 64'(out_valid), 64'h1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(in_ready), 64'h0);
    cyc();
    rst      = 1'b0;
    in_valid = 4'b0000;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_data", 64'(out_data), 64'h0);
    chk("midrst_sel", 64'(out_sel), 64'h0);
    chk("midrst_ptr", 64'(dbg.ptr), 64'h0);

    // Randomized traffic, model-checked every cycle.
    repeat (2000) begin
      cyc();
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) in_data[i] = $urandom;
    end

`ifdef RR_MUX4_STATS_EN
    // Saturate channel 1's counter, then clear everything.
    cyc();
    rst = 1'b1;
    cyc();
    rst       = 1'b0;
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    repeat (70000) cyc();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("stats_ch1_sat", 64'(grant_cnt[31:16]), 64'hFFFF);
    chk("stats_others", 64'({grant_cnt[63:32], grant_cnt[15:0]}), 64'h0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("stats_clear", grant_cnt, 64'h0);
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
